riscv_dmem_resp: RTL and testbench
==================================

# riscv_dmem_resp

Data-memory responder for the single-cycle RISC-V core: the slave end of the core's `daddr/dwdata/drdata/dsize/drd/dwr` data port. It accepts one load or store at a time and stores words in an internal word-addressed array. Byte and halfword stores go to the correct little-endian lanes. Load data is returned right-justified and zero-extended after a programmable number of wait states, with a completion strobe and an error flag. It sits beside the core in the simulation top and is the block the core's load/store path is brought up against.

## Interface
Parameters:
- `MEM_WORDS`, 1024: array depth in 32-bit words; power of two, 16..65536.
- `WAIT_CYCLES`, 1: extra cycles between request acceptance and response; 0..15.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; asynchronous assert, active-low.
- `daddr_i`  in  32  byte address.
- `dwdata_i`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `dsize_i`  in  2  access size: 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 illegal.
- `drd_i`  in  1  load request.
- `dwr_i`  in  1  store request.
- `drdata_o`  out  32  load data, right-justified, zero-extended. The core performs sign extension.
- `dready_o`  out  1  one-cycle completion strobe.
- `derr_o`  out  1  error flag; valid when `dready_o`=1.

The clock is `clk_i`. `reset_i` is asynchronous and active-low. These choices are fixed.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **Acceptance.** A request (`drd_i|dwr_i`) is sampled on a rising edge while the FSM is in IDLE or RESP. On acceptance the block captures `daddr_i`, `dsize_i`, `dwdata_i` and the rd/wr bits.
- **Transitions.**
  - If `WAIT_CYCLES`=0, the FSM moves to RESP on acceptance.
  - Otherwise it moves to WAIT and loads the counter with `WAIT_CYCLES-1`.
  - WAIT decrements the counter each cycle and moves to RESP after the cycle in which the counter equals 0.
  - RESP with no new request returns to IDLE.
- Requests presented while in WAIT are ignored. The initiator holds its request until `dready_o` and must change or drop it in the `dready_o` cycle.
- **Word index.** The index is `daddr[log2(MEM_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `MEM_WORDS*4`.
- **Error conditions** (evaluated on the captured request):
  - `drd_i` and `dwr_i` both set;
  - size 2'b11;
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- **On error:** no array write, `drdata_o`=0 and `derr_o`=1 in RESP.
- **Store** (committed on the edge entering RESP):
  - Byte: only lane `addr[1:0]` is written.
  - Half: lanes `{addr[1],0}` and `{addr[1],1}` are written.
  - Word: all four lanes are written.
  - All other lanes are unchanged. `drdata_o` holds its previous value.
- **Load** (data registered on the edge entering RESP):
  - Byte: the selected lane, zero-extended.
  - Half: the selected half, zero-extended.
  - Word: the full word.
  - `drdata_o` holds until the next completed load or error.
- A load issued immediately after a store to the same word returns the stored value, because the store has committed before the load's data edge.
- Array contents are not reset. Benches preload the array or write before reading.

## Timing
- **Reset values:** state IDLE, counter 0, `drdata_o`=0, `dready_o`=0, `derr_o`=0.
- **Latency:** `dready_o` is high in the cycle after edge N+`WAIT_CYCLES`, where N is the acceptance edge. Total latency is therefore `WAIT_CYCLES`+1 cycles.
- `dready_o` and `derr_o` are high only in RESP, for exactly one cycle per accepted request.
- **Throughput:** a new request presented during RESP is accepted on that edge, with no IDLE gap. Peak rate is one access per `WAIT_CYCLES`+1 cycles.
- **Reset asserted mid-request** (in WAIT, or before the RESP edge): the pending store is discarded, no array write occurs, and outputs take their reset values immediately.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Word store/load:** `WAIT_CYCLES`=1. Store word 0xDEADBEEF at 0x10, then load 0x10. Required: `dready_o` two cycles after each acceptance, load `drdata_o`=0xDEADBEEF, `derr_o`=0.
- **Byte and half lanes:** after the word store above:
  - store byte 0x5A at 0x12, then load word 0x10 → 0xDE5ABEEF;
  - load byte 0x13 → 0x000000DE;
  - store half 0x1234 at 0x10, then load half 0x10 → 0x00001234.
- **Errors:** each of the following gives `derr_o`=1, `drdata_o`=0, and the array unchanged (verified by a word load of 0x10):
  - word load at 0x11;
  - half store at 0x13;
  - `dsize_i`=2'b11;
  - `drd_i`=`dwr_i`=1.
- **Back-to-back and wait states:** `WAIT_CYCLES`=2. Issue store 0x20, load 0x20 and load 0x24, each presented in the prior `dready_o` cycle. Required: `dready_o` pulses exactly 3 cycles apart, the first load returns the stored value, and no request is duplicated.
- **Wrap-around:** `MEM_WORDS`=16. Store 0xCAFEF00D at 0x40, then load 0x00 → 0xCAFEF00D.
- **Reset mid-wait:** `WAIT_CYCLES`=3. Store 0x11111111 at 0x30 (preloaded 0x0). Assert `reset_i` in the second WAIT cycle. Required: all outputs 0 immediately, no `dready_o` pulse, and a subsequent load of 0x30 returns 0x0.

Source files
------------

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the single-cycle RISC-V core: one load/store at a time,
// little-endian byte lanes, programmable wait states, registered response.
module riscv_dmem_resp #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [1:0]  dsize_i,
    input  logic        drd_i,
    input  logic        dwr_i,
    output logic [31:0] drdata_o,
    output logic        dready_o,
    output logic        derr_o
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] drdata_q, drdata_d;
    logic        dready_q, dready_d;
    logic        derr_q, derr_d;

    logic        accept_s;
    logic        enter_resp_s;
    logic [31:0] eff_addr_s;
    logic [31:0] eff_wdata_s;
    logic [1:0]  eff_size_s;
    logic        eff_rd_s;
    logic        eff_wr_s;
    logic [AW-1:0] idx_s;
    logic        err_s;
    logic [3:0]  mask_s;
    logic [31:0] wdata_rep_s;
    logic [31:0] rword_s;
    logic        we_s;
    logic        unused_addr_s;

    logic [31:0] mem_q [MEM_WORDS];

    function automatic logic req_error(input logic rd, input logic wr,
                                       input logic [1:0] size, input logic [1:0] lo);
        logic e;
        case (size)
            2'b00:   e = rd & wr;
            2'b01:   e = (rd & wr) | lo[0];
            2'b10:   e = (rd & wr) | (lo != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lo);
        logic [31:0] sh;
        logic [31:0] r;
        case (size)
            2'b00: begin
                sh = word >> {lo, 3'b000};
                r  = {24'h000000, sh[7:0]};
            end
            2'b01: begin
                sh = word >> {lo[1], 4'b0000};
                r  = {16'h0000, sh[15:0]};
            end
            default: begin
                sh = word;
                r  = word;
            end
        endcase
        return r;
    endfunction

    assign accept_s = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && (drd_i || dwr_i);

    // With no wait states the response uses the live request; otherwise the captured one.
    always_comb begin
        if (ZERO_WAIT) begin
            eff_addr_s  = daddr_i;
            eff_wdata_s = dwdata_i;
            eff_size_s  = dsize_i;
            eff_rd_s    = drd_i;
            eff_wr_s    = dwr_i;
        end else begin
            eff_addr_s  = addr_q;
            eff_wdata_s = wdata_q;
            eff_size_s  = size_q;
            eff_rd_s    = rd_q;
            eff_wr_s    = wr_q;
        end
    end

    // Next-state logic, wait counter and request capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    addr_d  = daddr_i;
                    wdata_d = dwdata_i;
                    size_d  = dsize_i;
                    rd_d    = drd_i;
                    wr_d    = dwr_i;
                    if (ZERO_WAIT) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign idx_s         = eff_addr_s[AW+1:2];
    assign err_s         = req_error(eff_rd_s, eff_wr_s, eff_size_s, eff_addr_s[1:0]);
    assign mask_s        = lane_mask(eff_size_s, eff_addr_s[1:0]);
    assign wdata_rep_s   = replicate(eff_size_s, eff_wdata_s);
    assign rword_s       = mem_q[idx_s];
    // reset_i gates the write so a zero-wait store cannot commit while reset is held.
    assign we_s          = enter_resp_s & eff_wr_s & ~err_s & reset_i;
    assign unused_addr_s = ^{eff_addr_s[31:AW+2], addr_q[31:AW+2]};

    // Response data and strobes for the cycle after the RESP-entry edge.
    always_comb begin
        drdata_d = drdata_q;
        dready_d = enter_resp_s;
        derr_d   = enter_resp_s & err_s;
        if (enter_resp_s) begin
            if (err_s) begin
                drdata_d = 32'h0000_0000;
            end else if (eff_rd_s) begin
                drdata_d = load_extract(rword_s, eff_size_s, eff_addr_s[1:0]);
            end else begin
                drdata_d = drdata_q;
            end
        end else begin
            drdata_d = drdata_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            size_q   <= 2'b00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            drdata_q <= 32'h0000_0000;
            dready_q <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            drdata_q <= drdata_d;
            dready_q <= dready_d;
            derr_q   <= derr_d;
        end
    end

    // Byte-lane store into the array; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_s && mask_s[b]) begin
                mem_q[idx_s][8*b +: 8] <= wdata_rep_s[8*b +: 8];
            end
        end
    end

    assign drdata_o = drdata_q;
    assign dready_o = dready_q;
    assign derr_o   = derr_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Randomized self-checking bench for riscv_dmem_resp against a byte-level memory model.
module tb_riscv_dmem_resp;

    localparam int DEPTH = 16;
    localparam int W     = 2;

    logic        clk_i;
    logic        reset_i;
    logic [31:0] daddr_i;
    logic [31:0] dwdata_i;
    logic [1:0]  dsize_i;
    logic        drd_i;
    logic        dwr_i;
    logic [31:0] drdata_o;
    logic        dready_o;
    logic        derr_o;

    riscv_dmem_resp #(.MEM_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .daddr_i  (daddr_i),
        .dwdata_i (dwdata_i),
        .dsize_i  (dsize_i),
        .drd_i    (drd_i),
        .dwr_i    (dwr_i),
        .drdata_o (drdata_o),
        .dready_o (dready_o),
        .derr_o   (derr_o)
    );

    typedef struct {
        int          due;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } req_t;

    int          checks   = 0;
    int          errors   = 0;
    int          edge_cnt = 0;
    bit          checking = 1'b0;
    req_t        pend_q[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] hold_m = 32'h0;
    req_t        cur_r;
    logic        cur_err;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one completed request to the model in order of completion.
    task automatic model_resp(input req_t r, output logic err);
        int off;
        int wi;
        int nbytes;
        off    = int'(r.addr % 32'd4);
        wi     = int'((r.addr / 32'd4) % 32'(DEPTH));
        nbytes = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        err    = (r.rd && r.wr) || (r.size == 2'd3) ||
                 (r.size == 2'd1 && (off % 2) != 0) || (r.size == 2'd2 && off != 0);
        if (err) begin
            hold_m = 32'h0;
        end else if (r.wr) begin
            for (int k = 0; k < nbytes; k++) mem_m[wi][8*(off+k) +: 8] = r.wdata[8*k +: 8];
        end else begin
            hold_m = 32'h0;
            for (int k = 0; k < nbytes; k++) hold_m[8*k +: 8] = mem_m[wi][8*(off+k) +: 8];
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_i) begin
        if (checking) begin
            if (pend_q.size() > 0 && pend_q[0].due == edge_cnt) begin
                cur_r = pend_q.pop_front();
                model_resp(cur_r, cur_err);
                check("dready_resp", 32'(dready_o), 32'd1);
                check("derr_resp", 32'(derr_o), 32'(cur_err));
                check("drdata_resp", drdata_o, hold_m);
            end else begin
                check("dready_idle", 32'(dready_o), 32'd0);
                check("derr_idle", 32'(derr_o), 32'd0);
                check("drdata_hold", drdata_o, hold_m);
            end
        end
    end

    // Present a request at a falling edge and return at the falling edge of its dready cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size);
        req_t r;
        drd_i    = rd;
        dwr_i    = wr;
        daddr_i  = addr;
        dwdata_i = wdata;
        dsize_i  = size;
        r.due    = edge_cnt + 1 + W;
        r.rd     = rd;
        r.wr     = wr;
        r.addr   = addr;
        r.wdata  = wdata;
        r.size   = size;
        pend_q.push_back(r);
        repeat (W + 1) @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        drd_i = 1'b0;
        dwr_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          kind;
        reset_i  = 1'b0;
        drd_i    = 1'b0;
        dwr_i    = 1'b0;
        daddr_i  = 32'h0;
        dwdata_i = 32'h0;
        dsize_i  = 2'd0;
        #1;
        check("reset_drdata", drdata_o, 32'h0);
        check("reset_dready", 32'(dready_o), 32'd0);
        check("reset_derr", 32'(derr_o), 32'd0);
        repeat (3) @(negedge clk_i);
        reset_i  = 1'b1;
        checking = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 2'd2);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2);
        check("st_word_derr", 32'(derr_o), 32'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd2);
        check("ld_word", drdata_o, 32'hDEADBEEF);
        check("ld_word_ready", 32'(dready_o), 32'd1);
        do_req(1'b0, 1'b1, 32'h12, 32'h0000005A, 2'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd2);
        check("ld_after_byte", drdata_o, 32'hDE5ABEEF);
        do_req(1'b1, 1'b0, 32'h13, 32'h0, 2'd0);
        check("ld_byte", drdata_o, 32'h000000DE);
        do_req(1'b0, 1'b1, 32'h10, 32'h00001234, 2'd1);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd1);
        check("ld_half", drdata_o, 32'h00001234);

        do_req(1'b1, 1'b0, 32'h11, 32'h0, 2'd2);
        check("err_misword", 32'(derr_o), 32'd1);
        check("err_misword_data", drdata_o, 32'h0);
        do_req(1'b0, 1'b1, 32'h13, 32'h0000FFFF, 2'd1);
        check("err_mishalf", 32'(derr_o), 32'd1);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd3);
        check("err_size3", 32'(derr_o), 32'd1);
        do_req(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 2'd2);
        check("err_rdwr", 32'(derr_o), 32'd1);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 2'd2);
        check("err_unchanged", drdata_o, 32'hDE5A1234);

        do_req(1'b0, 1'b1, 32'h24, 32'h24242424, 2'd2);
        do_req(1'b0, 1'b1, 32'h20, 32'hA5A5C3C3, 2'd2);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 2'd2);
        check("b2b_ld0", drdata_o, 32'hA5A5C3C3);
        do_req(1'b1, 1'b0, 32'h24, 32'h0, 2'd2);
        check("b2b_ld1", drdata_o, 32'h24242424);
        idle(2);

        do_req(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'd2);
        do_req(1'b1, 1'b0, 32'h00, 32'h0, 2'd2);
        check("wrap", drdata_o, 32'hCAFEF00D);

        do_req(1'b0, 1'b1, 32'h30, 32'h0, 2'd2);
        idle(1);
        drd_i    = 1'b0;
        dwr_i    = 1'b1;
        daddr_i  = 32'h30;
        dwdata_i = 32'h11111111;
        dsize_i  = 2'd2;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        dwr_i   = 1'b0;
        pend_q.delete();
        hold_m  = 32'h0;
        #1;
        check("rst_mid_drdata", drdata_o, 32'h0);
        check("rst_mid_dready", 32'(dready_o), 32'd0);
        check("rst_mid_derr", 32'(derr_o), 32'd0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        idle(2);
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 2'd2);
        check("rst_no_store", drdata_o, 32'h0);

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
                else a[1:0] = a[1:0];
            end
            do_req(kind <= 4 || kind == 9, kind >= 5, a, $urandom, sz);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
        end
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
